event_packer: RTL

- Builds framed detector events and buffers them for the HPS RAM-transfer controller.
- Sits directly upstream of the SoC to_ram FIFO port:
  - drives fifo_data_event and fifo_data_empty;
  - consumes fifo_data_ack.
- Each trigger produces one frame: header, trigger number, payload words, optional checksum, trailer.
- Frames are stored in an internal show-ahead FIFO.

---
 rtl/daq_event_pkg.sv | 27 ++
 rtl/sync_fifo_fwft.sv | 79 +++++++
 rtl/event_packer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/daq_event_pkg.sv
// Shared definitions for the event packer: frame constants, trailer layout and FSM states.
package daq_event_pkg;

   localparam logic [31:0] HEADER_MAGIC_DEF = 32'hEE1234EE;
   localparam logic [3:0]  TRL_TAG          = 4'hF;
   localparam int          TRL_TRUNC_BIT    = 27;
   localparam int          TRL_CNT_W        = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      TRG  = 3'd2,
      PAY  = 3'd3,
      CRC  = 3'd4,
      TRL  = 3'd5
   } state_t;

   function automatic logic [31:0] make_trailer(input logic trunc, input logic [TRL_CNT_W-1:0] cnt);
      logic [31:0] w;
      w                = 32'h0000_0000;
      w[31:28]         = TRL_TAG;
      w[TRL_TRUNC_BIT] = trunc;
      w[TRL_CNT_W-1:0] = cnt;
      return w;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered head word and registered level.
module sync_fifo_fwft #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic [$clog2(DEPTH):0]   free_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic [WIDTH-1:0] head_q;
   logic             wr_ok_s;
   logic             rd_ok_s;
   logic             empty_s;
   logic             full_s;
   logic [AW-1:0]    rd_nxt_s;

   assign empty_s  = (level_q == {LW{1'b0}});
   assign full_s   = (level_q == LW'(DEPTH));
   assign wr_ok_s  = wr_en_i && !full_s;
   assign rd_ok_s  = rd_en_i && !empty_s;
   assign rd_nxt_s = rd_ptr_q + AW'(1);

   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // head_q mirrors the oldest stored word; it takes the write data directly when the FIFO is (becoming) empty
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {LW{1'b0}};
         head_q   <= {WIDTH{1'b0}};
      end else begin
         if (wr_ok_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (rd_ok_s) begin
            rd_ptr_q <= rd_nxt_s;
         end
         case ({wr_ok_s, rd_ok_s})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
         if (empty_s || (rd_ok_s && (level_q == LW'(1)))) begin
            if (wr_ok_s) begin
               head_q <= wr_data_i;
            end
         end else if (rd_ok_s) begin
            head_q <= mem_q[rd_nxt_s];
         end
      end
   end

   assign rd_data_o = head_q;
   assign empty_o   = empty_s;
   assign full_o    = full_s;
   assign level_o   = level_q;
   assign free_o    = LW'(DEPTH) - level_q;

endmodule

// File: rtl/event_packer.sv
// Frames detector events (header, trigger number, payload, optional checksum, trailer) into a FWFT FIFO.
// Optional checksum word enabled by defining EVENT_PACKER_CHECKSUM_EN.
module event_packer
   import daq_event_pkg::*;
#(
   parameter int unsigned DEPTH        = 512,
   parameter int unsigned MAX_WORDS    = 1024,
   parameter logic [31:0] HEADER_MAGIC = HEADER_MAGIC_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   trig_in,
   input  logic [31:0]            trig_num,
   input  logic [31:0]            data_in,
   input  logic                   data_valid,
   input  logic                   data_last,
   output logic                   data_ready,
   output logic [31:0]            fifo_data_event,
   output logic                   fifo_data_empty,
   input  logic                   fifo_data_ack,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [31:0]            event_count,
   output logic [15:0]            trig_dropped,
   output logic                   busy
);

   localparam int          LW       = $clog2(DEPTH) + 1;
   localparam logic [15:0] MAX_W16  = 16'(MAX_WORDS);
   localparam logic [LW-1:0] FREE_MIN = LW'(2);

   state_t        state_q, state_d;
   logic [31:0]   trig_q, trig_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          trunc_q, trunc_d;
   logic [31:0]   evcnt_q, evcnt_d;
   logic [15:0]   drop_q, drop_d;
`ifdef EVENT_PACKER_CHECKSUM_EN
   logic [31:0]   csum_q, csum_d;
`endif

   logic          wr_en_s;
   logic [31:0]   wr_data_s;
   logic          fifo_full_s;
   logic [LW-1:0] fifo_free_s;
   logic          at_max_s;
   logic          trig_ok_s;
   logic          ready_s;
   logic          xfer_s;

   // Once MAX_WORDS are stored, further words are swallowed, so they must not wait on FIFO space
   assign at_max_s  = (cnt_q >= MAX_W16);
   assign trig_ok_s = enable && (fifo_free_s >= FREE_MIN);
   assign ready_s   = (state_q == PAY) && (!fifo_full_s || at_max_s);
   assign xfer_s    = data_valid && ready_s;

   always_comb begin
      state_d   = state_q;
      trig_d    = trig_q;
      cnt_d     = cnt_q;
      trunc_d   = trunc_q;
      evcnt_d   = evcnt_q;
      drop_d    = drop_q;
      wr_en_s   = 1'b0;
      wr_data_s = 32'h0000_0000;
`ifdef EVENT_PACKER_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      if (trig_in && ((state_q != IDLE) || !trig_ok_s) && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end else begin
         drop_d = drop_q;
      end

      case (state_q)
         IDLE: begin
            if (trig_in && trig_ok_s) begin
               trig_d  = trig_num;
               cnt_d   = 16'd0;
               trunc_d = 1'b0;
`ifdef EVENT_PACKER_CHECKSUM_EN
               csum_d  = 32'h0000_0000;
`endif
               state_d = HDR;
            end else begin
               state_d = IDLE;
            end
         end
         HDR: begin
            if (!fifo_full_s) begin
               wr_en_s   = 1'b1;
               wr_data_s = HEADER_MAGIC;
               state_d   = TRG;
            end else begin
               state_d   = HDR;
            end
         end
         TRG: begin
            if (!fifo_full_s) begin
               wr_en_s   = 1'b1;
               wr_data_s = trig_q;
               state_d   = PAY;
            end else begin
               state_d   = TRG;
            end
         end
         PAY: begin
            if (xfer_s) begin
               if (!at_max_s) begin
                  wr_en_s   = 1'b1;
                  wr_data_s = data_in;
                  cnt_d     = cnt_q + 16'd1;
`ifdef EVENT_PACKER_CHECKSUM_EN
                  csum_d    = csum_q ^ data_in;
`endif
               end else begin
                  trunc_d   = 1'b1;
               end
               if (data_last) begin
`ifdef EVENT_PACKER_CHECKSUM_EN
                  state_d = CRC;
`else
                  state_d = TRL;
`endif
               end else begin
                  state_d = PAY;
               end
            end else begin
               state_d = PAY;
            end
         end
`ifdef EVENT_PACKER_CHECKSUM_EN
         CRC: begin
            if (!fifo_full_s) begin
               wr_en_s   = 1'b1;
               wr_data_s = csum_q;
               state_d   = TRL;
            end else begin
               state_d   = CRC;
            end
         end
`endif
         TRL: begin
            if (!fifo_full_s) begin
               wr_en_s   = 1'b1;
               wr_data_s = make_trailer(trunc_q, cnt_q);
               evcnt_d   = evcnt_q + 32'd1;
               state_d   = IDLE;
            end else begin
               state_d   = TRL;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         trig_q  <= 32'h0000_0000;
         cnt_q   <= 16'd0;
         trunc_q <= 1'b0;
         evcnt_q <= 32'd0;
         drop_q  <= 16'd0;
`ifdef EVENT_PACKER_CHECKSUM_EN
         csum_q  <= 32'h0000_0000;
`endif
      end else begin
         state_q <= state_d;
         trig_q  <= trig_d;
         cnt_q   <= cnt_d;
         trunc_q <= trunc_d;
         evcnt_q <= evcnt_d;
         drop_q  <= drop_d;
`ifdef EVENT_PACKER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   sync_fifo_fwft #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en_s),
      .wr_data_i (wr_data_s),
      .rd_en_i   (fifo_data_ack),
      .rd_data_o (fifo_data_event),
      .empty_o   (fifo_data_empty),
      .full_o    (fifo_full_s),
      .level_o   (fifo_level),
      .free_o    (fifo_free_s)
   );

   assign data_ready   = ready_s;
   assign event_count  = evcnt_q;
   assign trig_dropped = drop_q;
   assign busy         = (state_q != IDLE);

endmodule
